// File: rtl/yolo_pkg.sv
// Shared constants and types for the YOLO conv output path.
// Holds the leaky-ReLU ratio, int8 limits, lane geometry and the packed word type.
// Also carries the int8 saturation helper used by the requant stage.
package yolo_pkg;

  // Leaky-ReLU slope is 13/128 (about 0.1016), applied as multiply then arithmetic shift.
  localparam int LEAKY_NUM   = 13;
  localparam int LEAKY_SHIFT = 7;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  localparam int ACC_W = 32;
  localparam int LANES = 8;

  // Leaky intermediate width: 32-bit accumulator times a 4-bit constant.
  localparam int LEAKY_W = ACC_W + 4;
  // Requant product width: 32-bit signed times 17-bit signed (zero-extended 16-bit M).
  localparam int PROD_W = 49;
  // One bit of headroom so adding the rounding constant can never wrap.
  localparam int RND_W = PROD_W + 1;

  // Eight int8 lanes, lane k at bits [8k+7:8k].
  typedef logic [LANES*8-1:0] pix8_t;
  typedef logic signed [RND_W-1:0] rnd_t;

  // Clamp a wide signed value into the int8 range.
  function automatic logic [7:0] sat_int8(input rnd_t v);
    logic [7:0] res;
    if (v > rnd_t'(INT8_MAX)) begin
      res = 8'h7F;
    end else if (v < rnd_t'(INT8_MIN)) begin
      res = 8'h80;
    end else begin
      res = 8'(v);
    end
    return res;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous show-ahead FIFO: head word is visible on pop_dat whenever empty=0.
// Latency: a push is visible at the head on the edge after it is written (if it was empty).
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one wrap bit so full and empty can be told apart.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Empty FIFO presents zero rather than stale storage.
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/conv_requant_pack.sv
// Conv PE output stage: leaky-ReLU, requantize, saturate to int8, pack 8 lanes, buffer words.
// Latency: input registered at E0, S1 E1, S2 E2, S3 E3, word written to FIFO at E4.
// Backpressure: none toward the PE; a word completed while the FIFO is full is dropped and flagged.
module conv_requant_pack
  import yolo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic                    acc_valid,
  input  logic                    leaky_en,
  input  logic [15:0]             scale_m,
  input  logic [4:0]              scale_shift,
  output pix8_t                   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic                    busy
);

  // Input capture stage.
  logic                    in_vld_q;
  logic signed [ACC_W-1:0] in_dat_q;

  // S1: leaky-ReLU result.
  logic                    s1_vld_q;
  logic signed [ACC_W-1:0] s1_dat_q, s1_dat_d;
  logic signed [LEAKY_W-1:0] leaky_prod;

  // S2: requant product.
  logic                     s2_vld_q;
  logic signed [PROD_W-1:0] s2_dat_q, s2_dat_d;

  // S3: rounded, shifted, saturated int8.
  logic       s3_vld_q;
  logic [7:0] s3_dat_q, s3_dat_d;
  rnd_t       rnd_in;
  rnd_t       rnd_out;

  // Packer state.
  logic [2:0]              cnt_q, cnt_d;
  logic [(LANES-1)*8-1:0]  hold_q, hold_d;
  logic                    push;
  pix8_t                   push_dat;

  // FIFO handshake and status.
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic ovf_q, ovf_d;

  // Input register: the PE cannot stall, so every qualified value is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_vld_q <= 1'b0;
      in_dat_q <= '0;
    end else begin
      in_vld_q <= acc_valid;
      if (acc_valid) begin
        in_dat_q <= acc_in;
      end
    end
  end

  // S1 next value: negative inputs scaled by 13/128 with floor rounding when leaky is on.
  always_comb begin
    leaky_prod = LEAKY_W'(in_dat_q) * LEAKY_W'(LEAKY_NUM);
    s1_dat_d   = in_dat_q;
    if (leaky_en && in_dat_q[ACC_W-1]) begin
      s1_dat_d = ACC_W'(leaky_prod >>> LEAKY_SHIFT);
    end
  end

  // S1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= in_vld_q;
      if (in_vld_q) begin
        s1_dat_q <= s1_dat_d;
      end
    end
  end

  // S2 next value: signed times the unsigned multiplier widened with a zero sign bit.
  always_comb begin
    s2_dat_d = PROD_W'(s1_dat_q) * PROD_W'($signed({1'b0, scale_m}));
  end

  // S2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_q <= s2_dat_d;
      end
    end
  end

  // S3 next value: round half up by adding half an LSB before the arithmetic shift, then clamp.
  always_comb begin
    rnd_in  = rnd_t'(s2_dat_q);
    rnd_out = rnd_in;
    if (scale_shift != 5'd0) begin
      rnd_out = (rnd_in + (rnd_t'(1) <<< (scale_shift - 5'd1))) >>> scale_shift;
    end
    s3_dat_d = sat_int8(rnd_out);
  end

  // S3 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_vld_q <= 1'b0;
      s3_dat_q <= '0;
    end else begin
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        s3_dat_q <= s3_dat_d;
      end
    end
  end

  // Packer: lanes 0..6 collect in the holding register; lane 7 completes the word straight into the FIFO.
  always_comb begin
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    push     = 1'b0;
    push_dat = {s3_dat_q, hold_q};
    if (s3_vld_q) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        push = 1'b1;
      end else begin
        hold_d[{cnt_q, 3'b000} +: 8] = s3_dat_q;
      end
    end
  end

  // Packer registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  word_fifo #(
    .WIDTH ($bits(pix8_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Overflow is sticky: set only when a completed word finds no room and nothing leaves.
  always_comb begin
    ovf_d = ovf_q || (push && fifo_full && !pop);
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
  assign busy     = in_vld_q || s1_vld_q || s2_vld_q || s3_vld_q ||
                    (cnt_q != 3'd0) || !fifo_empty;

endmodule
